// File: rtl/debounce_bank.sv
// Multi-channel push-button conditioner: synchronises, debounces on a shared
// sample strobe and reports clean level, press/release pulses and long press.
module debounce_bank #(
    parameter int N          = 4,
    parameter int DEPTH      = 3,
    parameter int LONG_TICKS = 64
) (
    input  logic         clk,
    input  logic         resetb,
    input  logic         slowref,
    input  logic [N-1:0] swsig,
    output logic [N-1:0] cleansw,
    output logic [N-1:0] press_pulse,
    output logic [N-1:0] release_pulse,
    output logic [N-1:0] long_press,
    output logic [N-1:0] long_pulse
);

    localparam int CW = $clog2(LONG_TICKS + 1);

    typedef enum logic [1:0] {
        RELEASED = 2'd0,
        PRESSED  = 2'd1,
        LONG     = 2'd2
    } state_t;

    logic [N-1:0] sync1;
    logic [N-1:0] swsync;

    // NOTE: sequential state uses non-blocking assignments so both synchroniser
    // stages read their pre-edge values and the chain really is two flops deep.
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            sync1  <= '0;
            swsync <= '0;
        end else begin
            sync1  <= swsig;
            swsync <= sync1;
        end
    end

    for (genvar i = 0; i < N; i++) begin : g_ch
        logic [DEPTH-1:0] smp;
        logic             set;
        logic             clr;
        state_t           state;
        state_t           state_nxt;
        logic [CW-1:0]    cnt;
        logic [CW-1:0]    cnt_nxt;
        logic             clean_q,   clean_nxt;
        logic             press_q,   press_nxt;
        logic             rel_q,     rel_nxt;
        logic             long_q,    long_nxt;
        logic             lpulse_q,  lpulse_nxt;

        always_ff @(posedge clk or negedge resetb) begin
            if (!resetb) begin
                smp <= '0;
            end else if (slowref) begin
                smp <= {smp[DEPTH-2:0], swsync[i]};
            end
        end

        // Mixed sample windows assert neither, so the FSM simply holds.
        assign set = &smp;
        assign clr = ~|smp;

        always_ff @(posedge clk or negedge resetb) begin
            if (!resetb) begin
                state    <= RELEASED;
                cnt      <= '0;
                clean_q  <= 1'b0;
                press_q  <= 1'b0;
                rel_q    <= 1'b0;
                long_q   <= 1'b0;
                lpulse_q <= 1'b0;
            end else begin
                state    <= state_nxt;
                cnt      <= cnt_nxt;
                clean_q  <= clean_nxt;
                press_q  <= press_nxt;
                rel_q    <= rel_nxt;
                long_q   <= long_nxt;
                lpulse_q <= lpulse_nxt;
            end
        end

        // NOTE: every signal gets a default before the case so no path leaves
        // one unassigned, which would otherwise infer a latch.
        always_comb begin
            state_nxt  = state;
            cnt_nxt    = cnt;
            clean_nxt  = clean_q;
            press_nxt  = 1'b0;
            rel_nxt    = 1'b0;
            long_nxt   = long_q;
            lpulse_nxt = 1'b0;
            case (state)
                RELEASED: begin
                    if (set) begin
                        state_nxt = PRESSED;
                        clean_nxt = 1'b1;
                        press_nxt = 1'b1;
                        cnt_nxt   = '0;
                    end
                end
                PRESSED: begin
                    if (clr) begin
                        state_nxt = RELEASED;
                        clean_nxt = 1'b0;
                        rel_nxt   = 1'b1;
                    end else if (slowref) begin
                        cnt_nxt = cnt + 1'b1;
                        if (cnt_nxt == CW'(LONG_TICKS)) begin
                            state_nxt  = LONG;
                            long_nxt   = 1'b1;
                            lpulse_nxt = 1'b1;
                        end
                    end
                end
                LONG: begin
                    if (clr) begin
                        state_nxt = RELEASED;
                        clean_nxt = 1'b0;
                        long_nxt  = 1'b0;
                        rel_nxt   = 1'b1;
                    end
                end
                default: begin
                    state_nxt = RELEASED;
                    clean_nxt = 1'b0;
                    long_nxt  = 1'b0;
                end
            endcase
        end

        assign cleansw[i]       = clean_q;
        assign press_pulse[i]   = press_q;
        assign release_pulse[i] = rel_q;
        assign long_press[i]    = long_q;
        assign long_pulse[i]    = lpulse_q;
    end

endmodule

// File: tb/tb_debounce_bank.sv
// Bench for debounce_bank: directed scenarios plus randomized traffic, checked
// cycle by cycle against a run-length based behavioural model.
module tb_debounce_bank;

    localparam int N          = 4;
    localparam int DEPTH      = 3;
    localparam int LONG_TICKS = 5;

    logic         clk = 1'b0;
    logic         resetb;
    logic         slowref;
    logic [N-1:0] swsig;
    logic [N-1:0] cleansw;
    logic [N-1:0] press_pulse;
    logic [N-1:0] release_pulse;
    logic [N-1:0] long_press;
    logic [N-1:0] long_pulse;

    always #5 clk = ~clk;

    debounce_bank #(.N(N), .DEPTH(DEPTH), .LONG_TICKS(LONG_TICKS)) dut (
        .clk          (clk),
        .resetb       (resetb),
        .slowref      (slowref),
        .swsig        (swsig),
        .cleansw      (cleansw),
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse),
        .long_press   (long_press),
        .long_pulse   (long_pulse)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: inputs reach the sampler two edges late; each channel
    // tracks the value and length of its current run of equal samples.
    logic [N-1:0] pend[$];
    bit           run_val[N];
    int           run_len[N];
    int           ticks[N];
    logic [N-1:0] m_clean, m_press, m_rel, m_long, m_lp;

    int sr_mode = 0;
    int phase   = 0;
    int press_cnt[N];
    int rel_cnt[N];
    int lp_cnt[N];
    bit same_cycle;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        pend = {};
        pend.push_back('0);
        pend.push_back('0);
        for (int i = 0; i < N; i++) begin
            run_val[i] = 1'b0;
            run_len[i] = DEPTH;
            ticks[i]   = 0;
        end
        m_clean = '0; m_press = '0; m_rel = '0; m_long = '0; m_lp = '0;
    endtask

    task automatic model_step(input logic [N-1:0] sw, input logic sr);
        logic [N-1:0] src;
        bit set, clr;
        src = pend.pop_front();
        pend.push_back(sw);
        m_press = '0; m_rel = '0; m_lp = '0;
        for (int i = 0; i < N; i++) begin
            set = (run_len[i] >= DEPTH) && run_val[i];
            clr = (run_len[i] >= DEPTH) && !run_val[i];
            if (!m_clean[i] && set) begin
                m_clean[i] = 1'b1;
                m_press[i] = 1'b1;
                ticks[i]   = 0;
            end else if (m_clean[i] && clr) begin
                m_clean[i] = 1'b0;
                m_long[i]  = 1'b0;
                m_rel[i]   = 1'b1;
            end else if (m_clean[i] && !m_long[i] && sr) begin
                ticks[i]++;
                if (ticks[i] == LONG_TICKS) begin
                    m_long[i] = 1'b1;
                    m_lp[i]   = 1'b1;
                end
            end
            if (sr) begin
                if (src[i] == run_val[i]) begin
                    if (run_len[i] < DEPTH) run_len[i]++;
                end else begin
                    run_val[i] = src[i];
                    run_len[i] = 1;
                end
            end
        end
    endtask

    task automatic clear_counts();
        for (int i = 0; i < N; i++) begin
            press_cnt[i] = 0; rel_cnt[i] = 0; lp_cnt[i] = 0;
        end
        same_cycle = 1'b0;
    endtask

    // One clock: drive at the falling edge, model at the rising edge, compare
    // at the next falling edge.
    task automatic tick(input logic [N-1:0] sw, input string tag);
        swsig = sw;
        case (sr_mode)
            0:       slowref = (phase == 3);
            1:       slowref = 1'b1;
            default: slowref = 1'($urandom_range(0, 1));
        endcase
        phase = (phase + 1) % 4;
        @(posedge clk);
        if (resetb) model_step(sw, slowref);
        else        model_reset();
        @(negedge clk);
        check({tag, ".cleansw"}, 32'(cleansw), 32'(m_clean));
        check({tag, ".press"},   32'(press_pulse), 32'(m_press));
        check({tag, ".release"}, 32'(release_pulse), 32'(m_rel));
        check({tag, ".long"},    32'(long_press), 32'(m_long));
        check({tag, ".lpulse"},  32'(long_pulse), 32'(m_lp));
        for (int i = 0; i < N; i++) begin
            press_cnt[i] += int'(press_pulse[i]);
            rel_cnt[i]   += int'(release_pulse[i]);
            lp_cnt[i]    += int'(long_pulse[i]);
        end
        if (press_pulse[2] && release_pulse[3]) same_cycle = 1'b1;
    endtask

    task automatic hold(input logic [N-1:0] sw, input int nclk, input string tag);
        for (int k = 0; k < nclk; k++) tick(sw, tag);
    endtask

    initial begin
        logic [N-1:0] rsw;
        int           len;

        resetb  = 1'b0;
        slowref = 1'b0;
        swsig   = 4'hF;
        model_reset();
        @(negedge clk);

        // 1: reset holds everything low, then all four channels press together.
        hold(4'hF, 3, "s1_rst");
        check("s1_rst_clean", 32'(cleansw), 32'h0);
        resetb = 1'b1;
        phase  = 0;
        clear_counts();
        hold(4'hF, 12, "s1_pre");
        check("s1_not_yet", 32'(cleansw), 32'h0);
        hold(4'hF, 1, "s1_edge");
        check("s1_clean", 32'(cleansw), 32'hF);
        check("s1_press", 32'(press_pulse), 32'hF);
        hold(4'hF, 3, "s1_post");
        for (int i = 0; i < N; i++) check("s1_press_cnt", 32'(press_cnt[i]), 32'd1);

        hold(4'h0, 20, "release_all");
        check("release_all_clean", 32'(cleansw), 32'h0);

        // 2: bouncing channel 0 never settles, then settles high.
        clear_counts();
        hold(4'h1, 4, "s2_b");
        hold(4'h0, 4, "s2_b");
        hold(4'h1, 4, "s2_b");
        hold(4'h1, 4, "s2_b");
        hold(4'h0, 4, "s2_b");
        check("s2_bounce_press", 32'(press_cnt[0]), 32'd0);
        check("s2_bounce_clean", 32'(cleansw[0]), 32'd0);
        hold(4'h1, 16, "s2_settle");
        check("s2_press_cnt", 32'(press_cnt[0]), 32'd1);
        check("s2_clean", 32'(cleansw[0]), 32'd1);

        // 3: channel 1 held for 20 ticks reaches long press exactly once.
        clear_counts();
        hold(4'h3, 80, "s3_long");
        check("s3_press_cnt", 32'(press_cnt[1]), 32'd1);
        check("s3_lp_cnt", 32'(lp_cnt[1]), 32'd1);
        check("s3_long", 32'(long_press[1]), 32'd1);

        // 4: releasing from long press drops level and long together.
        clear_counts();
        hold(4'h1, 16, "s4_rel");
        check("s4_rel_cnt", 32'(rel_cnt[1]), 32'd1);
        check("s4_clean", 32'(cleansw[1]), 32'd0);
        check("s4_long", 32'(long_press[1]), 32'd0);

        // 5: channel 2 presses while channel 3 releases on the same samples.
        hold(4'h9, 16, "s5_pre");
        clear_counts();
        hold(4'h5, 16, "s5_swap");
        check("s5_same_cycle", 32'(same_cycle), 32'd1);
        check("s5_press3", 32'(press_cnt[3]), 32'd0);
        check("s5_rel0", 32'(rel_cnt[0]), 32'd0);

        // 6: reset while channel 0 is long-pressed, then restart.
        check("s6_ch0_long", 32'(long_press[0]), 32'd1);
        clear_counts();
        #2;
        resetb = 1'b0;
        model_reset();
        #1;
        check("s6_rst_clean", 32'(cleansw), 32'h0);
        check("s6_rst_long", 32'(long_press), 32'h0);
        check("s6_rst_rel", 32'(release_pulse), 32'h0);
        @(negedge clk);
        hold(4'h1, 3, "s6_in_rst");
        resetb = 1'b1;
        phase  = 0;
        hold(4'h1, 16, "s6_restart");
        check("s6_press_cnt", 32'(press_cnt[0]), 32'd1);
        check("s6_rel_cnt", 32'(rel_cnt[0]), 32'd0);

        // Randomized traffic: random strobe, then continuous strobe.
        for (int m = 2; m >= 1; m--) begin
            sr_mode = m;
            for (int s = 0; s < 60; s++) begin
                rsw = 4'($urandom);
                len = $urandom_range(1, 14);
                hold(rsw, len, m == 2 ? "rnd_strobe" : "rnd_cont");
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
